// File: rtl/mesh_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_pkg
//  Purpose  : Shared types and timing constants for the mesh sequencer.
//             The state enum is also used by the mesh testbench monitor.
//  Options  : MESH_CTRL_COPY_EN adds the COPY state.
//  Revision : 1.0  initial release
// ============================================================================
package mesh_pkg;

  localparam int IDX_WIDTH_FOR_NODES = 6;
  localparam int NUM_NODES           = 2 ** IDX_WIDTH_FOR_NODES;
  localparam int RD_LAT              = 1;
  localparam int NODE_LAT            = 3;
  localparam int WAIT_CYC            = NUM_NODES + RD_LAT + NODE_LAT;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_SWAP  = 3'd4,
    S_DONE  = 3'd5
`ifdef MESH_CTRL_COPY_EN
    , S_COPY = 3'd6
`endif
  } state_t;

  // Tail after the last feed column: last node's skew plus read and MAC latency.
  function automatic int wait_cycles(input int num_nodes, input int rd_lat, input int node_lat);
    return num_nodes + rd_lat + node_lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_ctrl_if
//  Purpose  : Command, BRAM and mesh-select bundle of the mesh sequencer.
//             master = sequencer side, slave = command source / mesh side.
//  Options  : MESH_CTRL_COPY_EN adds the copy command bit.
//  Revision : 1.0  initial release
// ============================================================================
interface mesh_ctrl_if #(
  parameter int IDX_WIDTH_FOR_NODES = 6,
  parameter int ADDR_W              = 10
);
  localparam int NUM_NODES = 2 ** IDX_WIDTH_FOR_NODES;

  logic                           start;
  logic [ADDR_W-1:0]              vec_len;
  logic [7:0]                     n_iter;
  logic                           use_init;
`ifdef MESH_CTRL_COPY_EN
  logic                           copy;
`endif
  logic                           busy;
  logic                           done;
  logic                           mbram_en;
  logic [ADDR_W-1:0]              mbram_addr;
  logic [ADDR_W-1:0]              vbram0_addr;
  logic                           vbram0_we;
  logic [ADDR_W-1:0]              vbram1_addr;
  logic                           vbram1_we;
  logic [1:0]                     asel;
  logic [NUM_NODES-1:0]           csels;
  logic [IDX_WIDTH_FOR_NODES-1:0] ressel;
  logic [1:0]                     dinsel;

  modport master (
    input  start, vec_len, n_iter, use_init,
`ifdef MESH_CTRL_COPY_EN
    input  copy,
`endif
    output busy, done, mbram_en, mbram_addr, vbram0_addr, vbram0_we,
           vbram1_addr, vbram1_we, asel, csels, ressel, dinsel
  );

  modport slave (
    output start, vec_len, n_iter, use_init,
`ifdef MESH_CTRL_COPY_EN
    output copy,
`endif
    input  busy, done, mbram_en, mbram_addr, vbram0_addr, vbram0_we,
           vbram1_addr, vbram1_we, asel, csels, ressel, dinsel
  );
endinterface
`default_nettype wire

// File: rtl/mesh_ctrl_skew_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : skew_strobe
//  Purpose  : Per-node start-of-accumulation strobes. A seed pulse at FEED
//             entry walks a shift register; tap i fires RD_LAT + i cycles
//             later, matching node i's i-cycle input skew.
//  Revision : 1.0  initial release
// ============================================================================
module skew_strobe #(
  parameter int NUM_NODES = 64,
  parameter int RD_LAT    = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  input  wire logic                 seed,
  output logic [NUM_NODES-1:0]      csels
);
  // RD_LAT-1 leading stages absorb the BRAM read latency before node 0's tap.
  localparam int c_LEN = NUM_NODES + RD_LAT - 1;

  logic [c_LEN-1:0] r_sr;

  // Shift the seed along; an async reset drops any strobe in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sr <= '0;
    else       r_sr <= {r_sr[c_LEN-2:0], seed};
  end

  assign csels = r_sr[RD_LAT-1 +: NUM_NODES];
endmodule
`default_nettype wire

// File: rtl/mesh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_ctrl
//  Purpose  : Sequencer for the systolic matrix-vector mesh. Runs n_iter
//             chained y = M*x passes, ping-ponging between vbram0/vbram1.
//  Options  : MESH_CTRL_COPY_EN adds a vbram0 -> vbram1 copy command.
//  Revision : 1.0  initial release
// ============================================================================
module mesh_ctrl
  import mesh_pkg::*;
#(
  parameter int IDX_WIDTH_FOR_NODES = 6,
  parameter int NUM_NODES           = 2 ** IDX_WIDTH_FOR_NODES,
  parameter int ADDR_W              = 10,
  parameter int RD_LAT              = 1,
  parameter int NODE_LAT            = 3
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  mesh_ctrl_if.master bus
);
  localparam int c_WAIT_CYC = wait_cycles(NUM_NODES, RD_LAT, NODE_LAT);
  // One counter serves FEED columns, WAIT cycles, DRAIN rows and COPY steps.
  localparam int c_CNT_W = ((ADDR_W > IDX_WIDTH_FOR_NODES + 2) ? ADDR_W : IDX_WIDTH_FOR_NODES + 2) + 1;

  state_t                         r_state, w_state_nxt;
  logic [c_CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic [7:0]                     r_pass, w_pass_nxt;
  logic [ADDR_W-1:0]              r_len;
  logic [7:0]                     r_niter;
  logic                           r_init;

  logic                           w_src;
  logic                           w_seed;
  logic                           w_busy, w_done, w_men, w_we0, w_we1;
  logic [ADDR_W-1:0]              w_maddr, w_addr0, w_addr1;
  logic [1:0]                     w_asel, w_dinsel;
  logic [IDX_WIDTH_FOR_NODES-1:0] w_ressel;
  logic                           w_copy;

`ifdef MESH_CTRL_COPY_EN
  assign w_copy = bus.copy;
`else
  assign w_copy = 1'b0;
`endif

  assign w_src = r_pass[0];

  // Latch the command on an accepted start so input changes mid-run are harmless.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len   <= '0;
      r_niter <= '0;
      r_init  <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_len   <= bus.vec_len;
      r_niter <= bus.n_iter;
      r_init  <= bus.use_init;
    end
  end

  // State, step counter and pass index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pass  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Next-state logic and per-state BRAM / mesh control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    w_seed      = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_men       = 1'b0;
    w_maddr     = '0;
    w_addr0     = '0;
    w_we0       = 1'b0;
    w_addr1     = '0;
    w_we1       = 1'b0;
    w_asel      = 2'b00;
    w_ressel    = '0;
    w_dinsel    = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_cnt_nxt  = '0;
          w_pass_nxt = '0;
          if (bus.vec_len == '0)                 w_state_nxt = S_DONE;
`ifdef MESH_CTRL_COPY_EN
          else if (w_copy)                       w_state_nxt = S_COPY;
`endif
          else if (bus.n_iter == 8'd0 || w_copy) w_state_nxt = S_DONE;
          else                                   w_state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        w_men   = 1'b1;
        w_maddr = r_cnt[ADDR_W-1:0];
        w_asel  = {r_init && (r_pass == 8'd0), w_src};
        w_seed  = (r_cnt == '0);
        if (w_src) w_addr1 = r_cnt[ADDR_W-1:0];
        else       w_addr0 = r_cnt[ADDR_W-1:0];
        if (r_cnt == c_CNT_W'(r_len) - c_CNT_W'(1)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
      end
      S_WAIT: begin
        w_asel = {r_init && (r_pass == 8'd0), w_src};
        if (r_cnt == c_CNT_W'(c_WAIT_CYC - 1)) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // res_selected follows ressel on the falling edge, so ressel and we share a cycle.
        w_asel   = {r_init && (r_pass == 8'd0), w_src};
        w_ressel = r_cnt[IDX_WIDTH_FOR_NODES-1:0];
        if (w_src) begin
          w_addr0 = r_cnt[ADDR_W-1:0];
          w_we0   = 1'b1;
        end else begin
          w_addr1 = r_cnt[ADDR_W-1:0];
          w_we1   = 1'b1;
        end
        if (r_cnt == c_CNT_W'(NUM_NODES - 1)) begin
          w_state_nxt = S_SWAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
      end
      S_SWAP: begin
        w_pass_nxt = r_pass + 8'd1;
        if (({1'b0, r_pass} + 9'd1) < {1'b0, r_niter}) w_state_nxt = S_FEED;
        else                                           w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
`ifdef MESH_CTRL_COPY_EN
      S_COPY: begin
        // Read address leads the write address by the BRAM read latency.
        w_dinsel = 2'b10;
        w_addr0  = r_cnt[ADDR_W-1:0];
        if (r_cnt >= c_CNT_W'(RD_LAT)) begin
          w_we1   = 1'b1;
          w_addr1 = ADDR_W'(r_cnt - c_CNT_W'(RD_LAT));
        end
        if (r_cnt == c_CNT_W'(r_len) + c_CNT_W'(RD_LAT - 1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
      end
`endif
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  skew_strobe #(
    .NUM_NODES (NUM_NODES),
    .RD_LAT    (RD_LAT)
  ) u_skew (
    .clk   (clk),
    .rstn  (rstn),
    .seed  (w_seed),
    .csels (bus.csels)
  );

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.mbram_en    = w_men;
  assign bus.mbram_addr  = w_maddr;
  assign bus.vbram0_addr = w_addr0;
  assign bus.vbram0_we   = w_we0;
  assign bus.vbram1_addr = w_addr1;
  assign bus.vbram1_we   = w_we1;
  assign bus.asel        = w_asel;
  assign bus.ressel      = w_ressel;
`ifdef MESH_CTRL_COPY_EN
  assign bus.dinsel      = w_dinsel;
`else
  assign bus.dinsel      = 2'b00;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mesh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mesh_ctrl
//  Purpose  : Self-checking bench for mesh_ctrl with a 4-node mesh. Expected
//             per-cycle controls come from the pass/phase arithmetic of the
//             sequencing rules; a transactional mesh + BRAM model turns the
//             DUT's controls into memory contents that are compared with
//             directly computed matrix-vector products.
//  Options  : MESH_CTRL_COPY_EN enables the copy scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mesh_ctrl;
  localparam int c_IDX  = 2;
  localparam int c_N    = 4;
  localparam int c_RD   = 1;
  localparam int c_NL   = 3;
  localparam int c_WAIT = c_N + c_RD + c_NL;
  localparam int unsigned c_INIT = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mesh_ctrl_if #(.IDX_WIDTH_FOR_NODES(c_IDX), .ADDR_W(10)) bus ();

  mesh_ctrl #(
    .IDX_WIDTH_FOR_NODES (c_IDX),
    .ADDR_W              (10),
    .RD_LAT              (c_RD),
    .NODE_LAT            (c_NL)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int unsigned vb0 [64];
  int unsigned vb1 [64];
  int unsigned mm  [c_N][64];
  int unsigned xs  [64];
  int          cols[64];
  int          nx;
  bit          prev_men;
  int unsigned rd_prev;

  function automatic logic [44:0] pk(logic b, logic d, logic me, logic [9:0] ma,
                                     logic [9:0] a0, logic w0, logic [9:0] a1, logic w1,
                                     logic [1:0] as, logic [3:0] cs, logic [1:0] rs, logic [1:0] di);
    return {b, d, me, ma, a0, w0, a1, w1, as, cs, rs, di};
  endfunction

  function automatic logic [44:0] obs_vec();
    return pk(bus.busy, bus.done, bus.mbram_en, bus.mbram_addr, bus.vbram0_addr, bus.vbram0_we,
              bus.vbram1_addr, bus.vbram1_we, bus.asel, bus.csels, bus.ressel, bus.dinsel);
  endfunction

  function automatic int run_len(input int len, input int niter, input bit cp);
    if (len == 0) return 1;
    if (cp) return len + c_RD + 1;
    if (niter == 0) return 1;
    return niter * (len + c_WAIT + c_N + 1) + 1;
  endfunction

  // Expected control outputs t cycles after the start was sampled.
  function automatic logic [44:0] exp_trace(input int t, input int len, input int niter,
                                            input bit init, input bit cp);
    int T, P, o, p, k;
    bit src;
    logic me, w0, w1;
    logic [9:0] ma, a0, a1;
    logic [1:0] as, rs, di;
    logic [3:0] cs;
    me = 0; w0 = 0; w1 = 0; ma = 0; a0 = 0; a1 = 0; as = 0; rs = 0; di = 0; cs = 0;
    T = run_len(len, niter, cp);
    if (t > T) return '0;
    if (t == T) return pk(1'b0, 1'b1, me, ma, a0, w0, a1, w1, as, cs, rs, di);
    if (cp) begin
      o  = t - 1;
      a0 = 10'(o);
      di = 2'b10;
      if (o >= c_RD) begin
        w1 = 1'b1;
        a1 = 10'(o - c_RD);
      end
      return pk(1'b1, 1'b0, me, ma, a0, w0, a1, w1, as, cs, rs, di);
    end
    P   = len + c_WAIT + c_N + 1;
    o   = (t - 1) % P;
    p   = (t - 1) / P;
    src = (p % 2) == 1;
    if (o < len + c_WAIT + c_N) as = {init && (p == 0), src};
    for (int i = 0; i < c_N; i++) cs[i] = (o == i + c_RD);
    if (o < len) begin
      me = 1'b1;
      ma = 10'(o);
      if (src) a1 = 10'(o); else a0 = 10'(o);
    end else if (o >= len + c_WAIT && o < len + c_WAIT + c_N) begin
      k  = o - len - c_WAIT;
      rs = 2'(k);
      if (src) begin a0 = 10'(k); w0 = 1'b1; end
      else     begin a1 = 10'(k); w1 = 1'b1; end
    end
    return pk(1'b1, 1'b0, me, ma, a0, w0, a1, w1, as, cs, rs, di);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transactional mesh + BRAMs driven by the DUT's controls for one cycle.
  task automatic mem_step();
    int unsigned xv, s;
    if (bus.mbram_en) begin
      if (!prev_men) nx = 0;
      xv = bus.asel[1] ? c_INIT : (bus.asel[0] ? vb1[bus.vbram1_addr[5:0]] : vb0[bus.vbram0_addr[5:0]]);
      if (nx < 64) begin
        cols[nx] = int'(bus.mbram_addr[5:0]);
        xs[nx]   = xv;
        nx++;
      end
    end
    prev_men = bus.mbram_en;
    if (bus.dinsel == 2'b00) begin
      s = 0;
      for (int j = 0; j < nx; j++) s += mm[bus.ressel][cols[j]] * xs[j];
      if (bus.vbram0_we) vb0[bus.vbram0_addr[5:0]] = s;
      if (bus.vbram1_we) vb1[bus.vbram1_addr[5:0]] = s;
    end else if (bus.dinsel == 2'b10) begin
      if (bus.vbram1_we) vb1[bus.vbram1_addr[5:0]] = rd_prev;
    end
    rd_prev = vb0[bus.vbram0_addr[5:0]];
  endtask

  task automatic drive_cmd(input int len, input int niter, input bit init, input bit cp);
    bus.vec_len  = 10'(len);
    bus.n_iter   = 8'(niter);
    bus.use_init = init;
`ifdef MESH_CTRL_COPY_EN
    bus.copy     = cp;
`endif
  endtask

  task automatic run_cmd(input int len, input int niter, input bit init, input bit cp);
    int unsigned e0 [64];
    int unsigned e1 [64];
    int unsigned y  [c_N];
    int unsigned x, s;
    int T;
    e0 = vb0;
    e1 = vb1;
    if (cp) begin
      for (int a = 0; a < len; a++) e1[a] = e0[a];
    end else begin
      for (int p = 0; p < niter && len > 0; p++) begin
        for (int k = 0; k < c_N; k++) begin
          s = 0;
          for (int c = 0; c < len; c++) begin
            x = (init && p == 0) ? c_INIT : ((p % 2) == 1 ? e1[c] : e0[c]);
            s += mm[k][c] * x;
          end
          y[k] = s;
        end
        for (int k = 0; k < c_N; k++) begin
          if ((p % 2) == 0) e1[k] = y[k]; else e0[k] = y[k];
        end
      end
    end
    T = run_len(len, niter, cp);
    @(negedge clk);
    bus.start = 1'b1;
    drive_cmd(len, niter, init, cp);
    @(negedge clk);
    nx = 0;
    prev_men = 1'b0;
    for (int t = 1; t <= T + 1; t++) begin
      chk($sformatf("trace len=%0d n=%0d t=%0d", len, niter, t), 64'(obs_vec()),
          64'(exp_trace(t, len, niter, init, cp)));
      mem_step();
      if (t < T && $urandom_range(0, 7) == 0) begin
        bus.start = 1'b1;
        drive_cmd(int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vb0[%0d]", i), 64'(vb0[i]), 64'(e0[i]));
      chk($sformatf("vb1[%0d]", i), 64'(vb1[i]), 64'(e1[i]));
    end
  endtask

  task automatic load_matrix(input int kind, input int unsigned scale);
    for (int r = 0; r < c_N; r++)
      for (int c = 0; c < 64; c++)
        case (kind)
          0:       mm[r][c] = (r == c) ? scale : 0;
          1:       mm[r][c] = 1;
          default: mm[r][c] = $urandom_range(0, 3);
        endcase
  endtask

  task automatic load_vecs(input bit rnd, input int unsigned v);
    for (int i = 0; i < 64; i++) begin
      vb0[i] = rnd ? $urandom_range(0, 7) : v;
      vb1[i] = $urandom_range(0, 7);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    drive_cmd(0, 0, 1'b0, 1'b0);
    nx = 0; prev_men = 1'b0; rd_prev = 0;
    repeat (3) @(negedge clk);
    chk("reset state", 64'(obs_vec()), 64'd0);
    rstn = 1'b1;

    // Identity pass copies x into vbram1.
    load_matrix(0, 1);
    load_vecs(1'b0, 0);
    for (int i = 0; i < 4; i++) vb0[i] = i + 1;
    run_cmd(4, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("ident vb1[%0d]", i), 64'(vb1[i]), 64'(i + 1));

    // Three chained 2x passes on an all-ones vector: 1 -> 2 -> 4 -> 8.
    load_matrix(0, 2);
    load_vecs(1'b0, 1);
    run_cmd(4, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("x8 vb1[%0d]", i), 64'(vb1[i]), 64'd8);

    // Constant init source with an all-ones matrix: 4 * 5.
    load_matrix(1, 0);
    load_vecs(1'b1, 0);
    run_cmd(4, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("init vb1[%0d]", i), 64'(vb1[i]), 64'd20);

    // Degenerate commands finish without BRAM activity.
    run_cmd(0, 3, 1'b0, 1'b0);
    run_cmd(5, 0, 1'b0, 1'b0);
    run_cmd(1, 2, 1'b0, 1'b0);

    // Reset in the middle of FEED aborts at once.
    @(negedge clk);
    bus.start = 1'b1;
    drive_cmd(8, 1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-feed busy", 64'(bus.busy), 64'd1);
    #2 rstn = 1'b0;
    #1 chk("async reset", 64'(obs_vec()), 64'd0);
    @(negedge clk);
    chk("reset next cycle", 64'(obs_vec()), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle after reset", 64'(obs_vec()), 64'd0);
    load_matrix(2, 0);
    load_vecs(1'b1, 0);
    run_cmd(8, 2, 1'b0, 1'b0);

    // Randomised commands, including vec_len beyond the node count.
    for (int r = 0; r < 6; r++) begin
      load_matrix(2, 0);
      load_vecs(1'b1, 0);
      run_cmd(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef MESH_CTRL_COPY_EN
    load_vecs(1'b1, 0);
    run_cmd(6, 1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) chk($sformatf("copy vb1[%0d]", i), 64'(vb1[i]), 64'(vb0[i]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mesh_ctrl.md
Name: mesh_ctrl

Overview:
- Sequencer for the systolic matrix-vector mesh. Issues matrix-BRAM and vector-BRAM addresses and write enables.
- Drives the mesh select lines (asel, csels, ressel, dinsel) to run n_iter chained y = M·x passes.
- Vector BRAMs are used ping-pong: each pass reads one and writes the other.
- Sits directly upstream of the mesh; it is the only driver of the mesh's control inputs.

Parameters:
- IDX_WIDTH_FOR_NODES, 6, log2 of node count.
- NUM_NODES, 2**IDX_WIDTH_FOR_NODES, matrix rows per tile = nodes in mesh.
- ADDR_W, 10, BRAM address width; vec_len max 2**ADDR_W-1.
- RD_LAT, 1, BRAM read latency in cycles.
- NODE_LAT, 3, node MAC pipeline latency, ain/bin to res.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- vec_len  in  ADDR_W  vector length / matrix columns; latched at start.
- n_iter  in  8  passes to run; latched at start.
- use_init  in  1  first pass feeds the constant init instead of vbram0; latched.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- mbram_en  out  1  matrix BRAM read enable.
- mbram_addr  out  ADDR_W  matrix column index.
- vbram0_addr  out  ADDR_W  vbram0 address.
- vbram0_we  out  1  vbram0 write enable.
- vbram1_addr  out  ADDR_W  vbram1 address.
- vbram1_we  out  1  vbram1 write enable.
- asel  out  2  mesh a-source: bit1 selects init, bit0 selects vbram1.
- csels  out  NUM_NODES  per-node start-new-accumulation strobe.
- ressel  out  IDX_WIDTH_FOR_NODES  node result routed to the vbram din.
- dinsel  out  2  vbram din source select.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset asserted mid-pass aborts immediately with no further writes.
- States: IDLE, FEED, WAIT, DRAIN, SWAP, DONE.
- Source/destination: pass p reads src = p[0], writes dst = ~p[0].
  - asel = {use_init && p==0, src}.
- IDLE:
  - start with vec_len==0 or n_iter==0 goes to DONE; no BRAM activity.
  - Otherwise latch inputs, clear p, go to FEED.
- FEED, cycles c = 0..vec_len-1:
  - mbram_en=1, mbram_addr=c, src vbram addr=c, we=0.
  - After the last column go to WAIT.
- csels[i] is a single pulse at cycle c = i + RD_LAT relative to FEED entry. This matches the node-i skew of i cycles, so every node starts a fresh sum on column 0. Pulses may extend into WAIT.
- WAIT: hold for NUM_NODES + RD_LAT + NODE_LAT cycles after the last feed; this covers the final node's skew and its result register. Then go to DRAIN.
- DRAIN, cycles k = 0..NUM_NODES-1:
  - ressel=k, dst vbram addr=k, dst we=1, dinsel=2'b00.
  - The mesh updates res_selected on the falling edge, so ressel and we are issued in the same cycle.
  - Then go to SWAP.
- SWAP, 1 cycle: p++. Go to FEED if p < n_iter, else DONE.
- DONE, 1 cycle: done=1, busy=0; return to IDLE.
- start outside IDLE is ignored.
- Only the dst vbram write enable is ever asserted; the two enables are never high together.
- vec_len > NUM_NODES is legal. Only addresses 0..NUM_NODES-1 are written; remaining entries keep their old data.
- The final result is in vbram(n_iter[0]).

Optional Feature:
- Macro MESH_CTRL_COPY_EN.
- Defined:
  - Adds input copy (1 bit) and state COPY.
  - start with copy=1 copies vbram0 into vbram1 through the mesh din bypass: dinsel=2'b10, read addr a, write addr a−RD_LAT, a = 0..vec_len-1+RD_LAT, vbram1_we only for write addr ≥0.
  - Then goes to DONE.
- Undefined: no copy port; dinsel is tied 2'b00.

Decomposition:
- Package mesh_pkg:
  - state enum, shared with the mesh testbench monitor;
  - localparam WAIT_CYC = NUM_NODES + RD_LAT + NODE_LAT.
- One sub-module, skew_strobe: a NUM_NODES-long shift register. It is seeded with 1 at FEED entry + RD_LAT, and its taps form csels.

Test Plan:
- Reset mid-FEED, vec_len=8 → all outputs 0 next cycle, no we; a new start runs cleanly.
- NUM_NODES=4, vec_len=4, n_iter=1, use_init=0, identity matrix, vbram0={1,2,3,4} → vbram1={1,2,3,4}; done exactly 4+4+1+3+1+4+1+1 cycles after start.
- n_iter=3, 2×identity, vbram0={1,1,1,1} → writes go vbram1, vbram0, vbram1; final vbram1={8,8,8,8}.
- use_init=1, init=5, all-ones 4×4 matrix, n_iter=1 → vbram1={20,20,20,20}; asel=2'b10 during FEED.
- start with vec_len=0 → done 2 cycles later; zero mbram_en/we. start while busy → ignored, single done.
- With MESH_CTRL_COPY_EN: copy=1, vec_len=6 → vbram1[0..5]==vbram0[0..5]; vbram0_we never asserted.
